rca_mp_seq: RTL

Multi-precision add sequencer that time-shares one CHUNK-bit `RCA_p` ripple-carry adder to add two WIDTH-bit operands. It processes one CHUNK-bit slice per clock, from least significant to most significant, and chains the carry through a register. A valid/ready handshake sits on both input and output, so the block fits between a producer and a consumer in the datapath. It trades latency for area: a CHUNK-bit adder does the work of a WIDTH-bit one.

---
 rtl/rca_mp_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rca_mp_seq.sv
// Multi-precision adder: one CHUNK-bit ripple-carry slice is reused for every
// slice of a WIDTH-bit add. Define RCA_MP_OVF_EN to add the signed-overflow output.

module RCA_p #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic [N-1:0] SUM,
  output logic         COUT
);
  logic [N:0] c;

  always_comb begin
    c[0] = CIN;
    for (int i = 0; i < N; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    COUT = c[N];
  end
endmodule

module rca_mp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_MP_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CHUNK-1:0] add_sum;
  logic             add_cout;

  RCA_p #(CHUNK) u_slice (
    .A    (a_reg[idx*CHUNK +: CHUNK]),
    .B    (b_reg[idx*CHUNK +: CHUNK]),
    .CIN  (carry),
    .SUM  (add_sum),
    .COUT (add_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef RCA_MP_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= add_sum;
          carry                   <= add_cout;
          if (idx == LAST_IDX) begin
            cout  <= add_cout;
`ifdef RCA_MP_OVF_EN
            // Top slice is being written this edge, so use the adder outputs directly.
            ovf   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ add_sum[CHUNK-1] ^ add_cout;
`endif
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
